// File: rtl/alu_rx_deserializer.sv
// Serial front end of the ALU: turns the single-wire packet stream into operands A/B,
// an opcode and per-frame error flags, one registered result per command packet.
module alu_rx_deserializer #(
  parameter logic [3:0] CRC_INIT = 4'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic        frame_valid,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [2:0]  op,
  output logic        err_data,
  output logic        err_crc,
  output logic        err_op
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RECV = 1'b1;

  logic [0:0]  r_state;
  logic [3:0]  r_bitCnt;
  logic [8:0]  r_shift;
  logic [3:0]  r_dataCnt;
  logic [63:0] r_buf;
  logic        r_corrupt;
  logic        r_cmdPend;
  logic [6:0]  r_cmdBits;

  logic [2:0]  w_op;
  logic [3:0]  w_crcCalc;
  logic        w_errData;
  logic        w_errCrc;
  logic        w_errOp;

  // Bit-serial CRC-4 (x^4+x+1), MSB first, unrolled into combinational logic.
  function automatic logic [3:0] crc4(input logic [67:0] msg);
    logic [3:0] c;
    logic       fb;
    c = CRC_INIT;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ msg[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  assign w_op      = r_cmdBits[6:4];
  assign w_crcCalc = crc4({r_buf, 1'b1, w_op});
  assign w_errData = r_corrupt || (r_dataCnt != 4'd8);
  assign w_errCrc  = !w_errData && (w_crcCalc != r_cmdBits[3:0]);
  // Legal opcodes 000/001/100/101 are exactly those with op[1] clear.
  assign w_errOp   = !w_errData && !w_errCrc && w_op[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bitCnt    <= 4'd0;
      r_shift     <= 9'd0;
      r_dataCnt   <= 4'd0;
      r_buf       <= 64'd0;
      r_corrupt   <= 1'b0;
      r_cmdPend   <= 1'b0;
      r_cmdBits   <= 7'd0;
      frame_valid <= 1'b0;
      A           <= 32'd0;
      B           <= 32'd0;
      op          <= 3'd0;
      err_data    <= 1'b0;
      err_crc     <= 1'b0;
      err_op      <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      err_data    <= 1'b0;
      err_crc     <= 1'b0;
      err_op      <= 1'b0;
      r_cmdPend   <= 1'b0;

      // Frame evaluation runs one cycle after the command stop bit.
      if (r_cmdPend) begin
        frame_valid <= 1'b1;
        err_data    <= w_errData;
        err_crc     <= w_errCrc;
        err_op      <= w_errOp;
        if (!w_errData && !w_errCrc && !w_errOp) begin
          A  <= r_buf[63:32];
          B  <= r_buf[31:0];
          op <= w_op;
        end
        r_dataCnt <= 4'd0;
        r_buf     <= 64'd0;
        r_corrupt <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (!sin) begin
            r_state  <= S_RECV;
            r_bitCnt <= 4'd0;
          end
        end
        default: begin
          if (r_bitCnt == 4'd9) begin
            r_state <= S_IDLE;
            if (!sin) begin
              r_corrupt <= 1'b1;
            end else if (r_shift[8]) begin
              r_cmdPend <= 1'b1;
              r_cmdBits <= r_shift[6:0];
            end else begin
              // Bytes arrive in order, so shifting left places byte 0 at A[31:24].
              if (r_dataCnt < 4'd8) begin
                r_buf <= {r_buf[55:0], r_shift[7:0]};
              end
              if (r_dataCnt != 4'd9) begin
                r_dataCnt <= r_dataCnt + 4'd1;
              end
            end
          end else begin
            r_shift  <= {r_shift[7:0], sin};
            r_bitCnt <= r_bitCnt + 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rx_deserializer.sv
// Self-checking bench for alu_rx_deserializer: directed frames plus randomized frames
// checked against a packet-level reference model.
module tb_alu_rx_deserializer;

  logic        clk;
  logic        rst_n;
  logic        sin;
  logic        frame_valid;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  op;
  logic        err_data;
  logic        err_crc;
  logic        err_op;

  int compared;
  int mismatched;
  int pulseCnt;
  int expFrames;

  logic [7:0]  dq[$];
  int          mCount;
  bit          mCorrupt;
  logic [31:0] eA;
  logic [31:0] eB;
  logic [2:0]  eOp;
  bit          eErrData;
  bit          eErrCrc;
  bit          eErrOp;

  alu_rx_deserializer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sin         (sin),
    .frame_valid (frame_valid),
    .A           (A),
    .B           (B),
    .op          (op),
    .err_data    (err_data),
    .err_crc     (err_crc),
    .err_op      (err_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (frame_valid === 1'b1) pulseCnt++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // CRC as polynomial long division of {msg, 0000} by 10011.
  function automatic logic [3:0] refCrc(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] o);
    logic [71:0] r;
    r = {a, b, 1'b1, o, 4'b0000};
    for (int i = 71; i >= 4; i--) begin
      if (r[i]) r[i-:5] = r[i-:5] ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  task automatic modelReset();
    dq.delete();
    mCount   = 0;
    mCorrupt = 0;
    eA       = 32'd0;
    eB       = 32'd0;
    eOp      = 3'd0;
  endtask

  task automatic modelPacket(input bit isCmd, input logic [7:0] pl, input bit stop);
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  o;
    if (!stop) begin
      mCorrupt = 1;
    end else if (!isCmd) begin
      if (dq.size() < 8) dq.push_back(pl);
      mCount++;
    end else begin
      o = pl[6:4];
      a = 32'd0;
      b = 32'd0;
      if (dq.size() == 8) begin
        a = {dq[0], dq[1], dq[2], dq[3]};
        b = {dq[4], dq[5], dq[6], dq[7]};
      end
      eErrData = mCorrupt || (mCount != 8);
      eErrCrc  = !eErrData && (refCrc(a, b, o) != pl[3:0]);
      eErrOp   = !eErrData && !eErrCrc && !(o inside {3'b000, 3'b001, 3'b100, 3'b101});
      if (!eErrData && !eErrCrc && !eErrOp) begin
        eA  = a;
        eB  = b;
        eOp = o;
      end
      expFrames++;
      dq.delete();
      mCount   = 0;
      mCorrupt = 0;
    end
  endtask

  task automatic sendIdle(input int n);
    repeat (n) begin
      @(negedge clk);
      sin = 1'b1;
    end
  endtask

  task automatic checkFrame();
    @(negedge clk);
    sin = 1'b1;
    checkOutput("fvEarly", 64'(frame_valid), 64'd0);
    @(negedge clk);
    checkOutput("fvPulse", 64'(frame_valid), 64'd1);
    checkOutput("errData", 64'(err_data), 64'(eErrData));
    checkOutput("errCrc", 64'(err_crc), 64'(eErrCrc));
    checkOutput("errOp", 64'(err_op), 64'(eErrOp));
    checkOutput("A", 64'(A), 64'(eA));
    checkOutput("B", 64'(B), 64'(eB));
    checkOutput("op", 64'(op), 64'(eOp));
    checkOutput("pulseCount", 64'(pulseCnt), 64'(expFrames));
    @(negedge clk);
    checkOutput("pulseEnd", 64'({frame_valid, err_data, err_crc, err_op}), 64'd0);
  endtask

  // Drives one 11-bit packet; the stop bit is sampled on the following rising edge.
  task automatic applyStimulus(input bit isCmd, input logic [7:0] pl, input bit stop);
    logic [10:0] bits;
    bits = {1'b0, isCmd, pl, stop};
    for (int i = 10; i >= 0; i--) begin
      @(negedge clk);
      sin = bits[i];
    end
    modelPacket(isCmd, pl, stop);
    if (isCmd && stop) checkFrame();
  endtask

  task automatic sendFrame(input logic [31:0] a, input logic [31:0] b,
                           input logic [7:0] cmd, input bit dropFirst);
    logic [63:0] ab;
    ab = {a, b};
    for (int i = 0; i < 8; i++) begin
      if (i == 0 && dropFirst) sendIdle(11);
      else applyStimulus(1'b0, ab[63-8*i -: 8], 1'b1);
    end
    applyStimulus(1'b1, cmd, 1'b1);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst_n = 1'b0;
    modelReset();
    @(negedge clk);
    sin = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  o;
    logic [3:0]  c;
    logic [63:0] ab;
    logic [7:0]  pl;
    int          nData;
    int          badIdx;
    int          pulsesBefore;
    compared   = 0;
    mismatched = 0;
    pulseCnt   = 0;
    expFrames  = 0;
    eErrData   = 0;
    eErrCrc    = 0;
    eErrOp     = 0;
    modelReset();
    rst_n = 1'b0;
    sin   = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    sendIdle(100);
    checkOutput("rstOutputs", 64'({frame_valid, err_data, err_crc, err_op, op}), 64'd0);
    checkOutput("rstA", 64'(A), 64'd0);
    checkOutput("rstB", 64'(B), 64'd0);
    checkOutput("rstPulses", 64'(pulseCnt), 64'd0);

    sendFrame(32'd0, 32'd0, 8'h0B, 1'b0);
    sendIdle(2);
    sendFrame(32'd0, 32'd0, 8'h47, 1'b0);
    sendFrame(32'd0, 32'd0, 8'h40, 1'b0);
    sendFrame(32'd0, 32'd0, 8'h0B, 1'b1);
    sendFrame(32'd0, 32'd0, 8'h3E, 1'b0);

    // Reset after three data packets, then a clean frame.
    pulsesBefore = pulseCnt;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h5A, 1'b1);
    pulseReset();
    sendIdle(3);
    checkOutput("abortNoPulse", 64'(pulseCnt), 64'(pulsesBefore));
    checkOutput("abortOutputs", 64'({A, op}), 64'd0);
    sendFrame(32'd0, 32'd0, 8'h0B, 1'b0);

    // Reset in the middle of a packet.
    applyStimulus(1'b0, 8'hC3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sin = (i == 0) ? 1'b0 : 1'(i % 2);
    end
    pulseReset();
    sendFrame(32'h12345678, 32'h9ABCDEF0, {1'b0, 3'b101, refCrc(32'h12345678, 32'h9ABCDEF0, 3'b101)}, 1'b0);

    for (int f = 0; f < 40; f++) begin
      a = $urandom;
      b = $urandom;
      o = 3'($urandom_range(0, 7));
      ab = {a, b};
      nData = 8;
      case ($urandom_range(0, 9))
        0: nData = 7;
        1: nData = 9;
        default: nData = 8;
      endcase
      badIdx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, nData - 1)) : -1;
      for (int i = 0; i < nData; i++) begin
        pl = (i < 8) ? ab[63-8*i -: 8] : 8'($urandom);
        applyStimulus(1'b0, pl, i != badIdx);
        sendIdle(int'($urandom_range(0, 2)));
      end
      if ($urandom_range(0, 19) == 0) applyStimulus(1'b1, 8'($urandom), 1'b0);
      c = ($urandom_range(0, 3) == 0) ? 4'($urandom) : refCrc(a, b, o);
      applyStimulus(1'b1, {1'($urandom), o, c}, 1'b1);
      sendIdle(int'($urandom_range(0, 3)));
    end

    sendIdle(5);
    checkOutput("finalPulses", 64'(pulseCnt), 64'(expFrames));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
